mbus_arbiter: RTL and testbench
===============================

# mbus_arbiter

Two-master arbiter for the computer's single memory bus. It shares one slave-side bus (address decoder, program/data memory, timer, GPIO) between the CPU (master 0) and a debug/DMA engine (master 1). Grants are registered, and ownership is bounded by a burst limit. The grant policy is fixed-priority by default, with an optional round-robin mode. It sits between the masters and the existing address decoder and slave mux, so slaves see a single master exactly as before.

## Interface
Parameters:
- WIDTH, 32, data/address width of both master ports and the slave port
- MAX_BURST, 8, maximum consecutive owned cycles while the other master waits; 0 disables preemption

Ports:
- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 (CPU) bus request, held for the whole access sequence
- m0_addr  in  WIDTH  master 0 address
- m0_dout  in  WIDTH  master 0 write data
- m0_wen  in  1  master 0 write enable
- m0_din  out  WIDTH  read data to master 0
- m0_gnt  out  1  master 0 owns the bus this cycle
- m1_req, m1_addr, m1_dout, m1_wen, m1_din, m1_gnt: same as m0_*, for master 1 (debug/DMA)
- s_addr  out  WIDTH  slave-side address
- s_dout  out  WIDTH  slave-side write data
- s_wen  out  1  slave-side write enable
- s_din  in  WIDTH  slave-side read data from the bus mux
- owner  out  2  00 none, 01 master 0, 10 master 1; 11 never occurs
- xfer_cnt  out  WIDTH  count of ownership changes into a master (IDLE→OWN or OWN→other OWN); wraps modulo 2^WIDTH

## Operation
- FSM states:
  - IDLE: owner=00.
  - OWN0: owner=01, m0_gnt=1.
  - OWN1: owner=10, m1_gnt=1.
- IDLE transitions:
  - Only m0_req → OWN0.
  - Only m1_req → OWN1.
  - Both requesting → winner set by policy (see Configuration).
  - Neither → stay in IDLE.
- OWNx transitions:
  - req_x low, other master requesting → OWN(other).
  - req_x low, other master idle → IDLE.
  - req_x high, other master requesting, burst_cnt == MAX_BURST-1, MAX_BURST≠0 → OWN(other) (preemption).
  - Otherwise → stay in OWNx.
- burst_cnt:
  - Width $clog2(MAX_BURST+1).
  - Cleared on every state change and in IDLE.
  - Increments each cycle in OWNx and saturates at MAX_BURST.
- Slave mux, combinational from state:
  - In OWNx: s_addr/s_dout = mx_addr/mx_dout; s_wen = mx_wen & mx_req.
  - In IDLE: s_addr=0, s_dout=0, s_wen=0.
- Read return:
  - Owner's m_din = s_din.
  - Non-owner's m_din = 0.
- A master whose gnt is low must hold req, addr, wen and data stable. The arbiter never issues a write for a non-owner.
- Preempted master keeps req high and regains the bus by normal arbitration.

## Timing
- Reset values:
  - State: IDLE.
  - owner=00, m0_gnt=m1_gnt=0, s_wen=0, s_addr=0, s_dout=0.
  - m0_din=m1_din=0, xfer_cnt=0, burst_cnt=0, last-served=master 1.
- Grant latency: req rising in cycle N, bus free → gnt high in cycle N+1. The access is performed in N+1.
- Release: req falls in cycle N → gnt low in N+1. A waiting master gets gnt in N+1 with no dead cycle.
- Preemption: with MAX_BURST=K and contention, the owner holds exactly K cycles, then the other master owns from cycle K+1.
- RESET asserted mid-access: outputs go to reset values immediately, asynchronously, and s_wen drops in the same cycle.
- Masters sample read data under the slave's own latency. The arbiter adds zero data-path latency.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Simultaneous requests from IDLE are granted to the master not last served. The last-served register updates on every entry to OWN0/OWN1.
  - The first contention after reset therefore goes to master 0.
- ARB_ROUND_ROBIN_EN undefined:
  - Simultaneous requests from IDLE always go to master 0.
  - The last-served register is not synthesized.
  - Preemption still applies in both modes.

## Structure
- Shared include header holds:
  - Owner encodings OWNER_NONE=2'b00, OWNER_M0=2'b01, OWNER_M1=2'b10.
  - FSM state encodings.
- No sub-module; the FSM, burst counter and slave mux form one flat module.

## Test plan
- Reset: RESET=1 → owner=00, s_wen=0, xfer_cnt=0. Release; no requests for 5 cycles → owner stays 00.
- Single master: m0_req=1, m0_addr=0x10, m0_wen=1, m0_dout=0xDEADBEEF → next cycle m0_gnt=1, s_addr=0x10, s_wen=1, xfer_cnt=1.
- Contention, fixed priority: both req in the same cycle from IDLE → OWN0. With MAX_BURST=8, m0 holds 8 cycles, then m1_gnt=1 in cycle 9 and xfer_cnt=2.
- Round-robin (ARB_ROUND_ROBIN_EN): m0 served and released. Then both request together → OWN1 granted first.
- Handover without gap: m1 owns, m0 waiting, m1_req drops in cycle N → m0_gnt=1 in N+1. m1_din=0 in N+1. m0_din=s_din.
- Reset mid-write: m1 owns with m1_wen=1, RESET pulses → s_wen=0 in the same cycle, owner=00, m1_gnt=0.

Source files
------------

// File: rtl/mbus_arbiter_pkg.sv
// Shared encodings for the two-master memory bus arbiter: owner codes and FSM states.
// The state codes equal the owner codes so the owner output is a direct view of the state.
package mbus_arbiter_pkg;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

endpackage

// File: rtl/mbus_arbiter.sv
// Two-master memory bus arbiter (CPU = master 0, debug/DMA = master 1) with registered grants and burst-limited ownership.
// Define ARB_ROUND_ROBIN_EN to let simultaneous requests from IDLE alternate instead of always favouring master 0.
module mbus_arbiter
  import mbus_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             m0_req,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_dout,
  input  logic             m0_wen,
  output logic [WIDTH-1:0] m0_din,
  output logic             m0_gnt,
  input  logic             m1_req,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_dout,
  input  logic             m1_wen,
  output logic [WIDTH-1:0] m1_din,
  output logic             m1_gnt,
  output logic [WIDTH-1:0] s_addr,
  output logic [WIDTH-1:0] s_dout,
  output logic             s_wen,
  input  logic [WIDTH-1:0] s_din,
  output logic [1:0]       owner,
  output logic [WIDTH-1:0] xfer_cnt
);

  localparam int BCW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [1:0]       w_contendWinner;
  logic [BCW-1:0]   r_burst;
  logic [WIDTH-1:0] r_xferCnt;
  logic             w_preempt;
  logic             w_enterOwn;

  // The owner is forced off once it has held the bus for MAX_BURST cycles while the other master waits.
  assign w_preempt  = (MAX_BURST != 0) && (r_burst == BCW'(MAX_BURST - 1));
  assign w_enterOwn = (w_next != r_state) && (w_next != ST_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_lastServed;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      r_lastServed <= 1'b1;
    else if (w_enterOwn)
      r_lastServed <= (w_next == ST_OWN1);
  end

  assign w_contendWinner = r_lastServed ? ST_OWN0 : ST_OWN1;
`else
  assign w_contendWinner = ST_OWN0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_req && m1_req)
          w_next = w_contendWinner;
        else if (m0_req)
          w_next = ST_OWN0;
        else if (m1_req)
          w_next = ST_OWN1;
      end
      ST_OWN0: begin
        if (!m0_req)
          w_next = m1_req ? ST_OWN1 : ST_IDLE;
        else if (m1_req && w_preempt)
          w_next = ST_OWN1;
      end
      ST_OWN1: begin
        if (!m1_req)
          w_next = m0_req ? ST_OWN0 : ST_IDLE;
        else if (m0_req && w_preempt)
          w_next = ST_OWN0;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_burst   <= '0;
      r_xferCnt <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || (r_state == ST_IDLE))
        r_burst <= '0;
      else if (r_burst != BCW'(MAX_BURST))
        r_burst <= r_burst + BCW'(1);
      if (w_enterOwn)
        r_xferCnt <= r_xferCnt + WIDTH'(1);
    end
  end

  assign xfer_cnt = r_xferCnt;

  // Slave mux and read return are purely combinational from the registered state: no added data latency.
  always_comb begin
    owner  = OWNER_NONE;
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    s_addr = '0;
    s_dout = '0;
    s_wen  = 1'b0;
    m0_din = '0;
    m1_din = '0;
    case (r_state)
      ST_OWN0: begin
        owner  = OWNER_M0;
        m0_gnt = 1'b1;
        s_addr = m0_addr;
        s_dout = m0_dout;
        s_wen  = m0_wen & m0_req;
        m0_din = s_din;
      end
      ST_OWN1: begin
        owner  = OWNER_M1;
        m1_gnt = 1'b1;
        s_addr = m1_addr;
        s_dout = m1_dout;
        s_wen  = m1_wen & m1_req;
        m1_din = s_din;
      end
      default: owner = OWNER_NONE;
    endcase
  end

endmodule

// File: tb/tb_mbus_arbiter.sv
// Directed self-checking bench for mbus_arbiter (MAX_BURST = 8); expected values follow ARB_ROUND_ROBIN_EN if defined.
module tb_mbus_arbiter;

  logic        CLK;
  logic        RESET;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m0_dout, m1_addr, m1_dout;
  logic        m0_wen, m1_wen;
  logic [31:0] m0_din, m1_din;
  logic        m0_gnt, m1_gnt;
  logic [31:0] s_addr, s_dout, s_din;
  logic        s_wen;
  logic [1:0]  owner;
  logic [31:0] xfer_cnt;

  int testsRun;
  int testsFailed;

  mbus_arbiter #(.WIDTH(32), .MAX_BURST(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_wen(m0_wen),
    .m0_din(m0_din), .m0_gnt(m0_gnt),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_wen(m1_wen),
    .m1_din(m1_din), .m1_gnt(m1_gnt),
    .s_addr(s_addr), .s_dout(s_dout), .s_wen(s_wen), .s_din(s_din),
    .owner(owner), .xfer_cnt(xfer_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [1:0] rrWinner;
    testsRun    = 0;
    testsFailed = 0;
    RESET   = 1'b1;
    m0_req  = 1'b0; m0_addr = '0; m0_dout = '0; m0_wen = 1'b0;
    m1_req  = 1'b0; m1_addr = '0; m1_dout = '0; m1_wen = 1'b0;
    s_din   = 32'h1234_5678;

    // Reset state
    tick(); tick();
    checkOutput("rst_owner", {30'd0, owner}, 32'd0);
    checkOutput("rst_swen", {31'd0, s_wen}, 32'd0);
    checkOutput("rst_xfer", xfer_cnt, 32'd0);
    checkOutput("rst_gnts", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    checkOutput("rst_din", m0_din | m1_din, 32'd0);
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("idle_owner", {30'd0, owner}, 32'd0);
    checkOutput("idle_saddr", s_addr, 32'd0);

    // Single master write
    m0_req = 1'b1; m0_addr = 32'h10; m0_wen = 1'b1; m0_dout = 32'hDEAD_BEEF;
    tick();
    checkOutput("single_gnt", {31'd0, m0_gnt}, 32'd1);
    checkOutput("single_owner", {30'd0, owner}, 32'd1);
    checkOutput("single_saddr", s_addr, 32'h10);
    checkOutput("single_sdout", s_dout, 32'hDEAD_BEEF);
    checkOutput("single_swen", {31'd0, s_wen}, 32'd1);
    checkOutput("single_xfer", xfer_cnt, 32'd1);
    checkOutput("single_m0din", m0_din, 32'h1234_5678);
    checkOutput("single_m1din", m1_din, 32'd0);
    m0_req = 1'b0; m0_wen = 1'b0;
    tick();
    checkOutput("release_owner", {30'd0, owner}, 32'd0);
    checkOutput("release_swen", {31'd0, s_wen}, 32'd0);

    // Contention straight after m0 was served
`ifdef ARB_ROUND_ROBIN_EN
    rrWinner = 2'b10;
`else
    rrWinner = 2'b01;
`endif
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    checkOutput("contend1_owner", {30'd0, owner}, {30'd0, rrWinner});
    checkOutput("contend1_xfer", xfer_cnt, 32'd2);
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    checkOutput("contend1_idle", {30'd0, owner}, 32'd0);

    // Contention with burst preemption; m1 holds a pending write that must not leak
    m0_addr = 32'h44; m0_wen = 1'b0;
    m1_addr = 32'h20; m1_dout = 32'hCAFE_F00D; m1_wen = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    checkOutput("burst_c1_owner", {30'd0, owner}, 32'd1);
    checkOutput("burst_c1_xfer", xfer_cnt, 32'd3);
    checkOutput("burst_c1_swen", {31'd0, s_wen}, 32'd0);
    for (int c = 2; c <= 8; c++) tick();
    checkOutput("burst_c8_m0gnt", {31'd0, m0_gnt}, 32'd1);
    checkOutput("burst_c8_xfer", xfer_cnt, 32'd3);
    tick();
    checkOutput("burst_c9_m1gnt", {31'd0, m1_gnt}, 32'd1);
    checkOutput("burst_c9_m0gnt", {31'd0, m0_gnt}, 32'd0);
    checkOutput("burst_c9_xfer", xfer_cnt, 32'd4);
    checkOutput("burst_c9_saddr", s_addr, 32'h20);
    checkOutput("burst_c9_swen", {31'd0, s_wen}, 32'd1);
    checkOutput("burst_c9_m1din", m1_din, 32'h1234_5678);
    checkOutput("burst_c9_m0din", m0_din, 32'd0);

    // Handover without gap: m1 drops request while m0 waits
    tick();
    m1_req = 1'b0;
    #1;
    checkOutput("handover_n_swen", {31'd0, s_wen}, 32'd0);
    checkOutput("handover_n_owner", {30'd0, owner}, 32'd2);
    s_din = 32'h0BAD_F00D;
    tick();
    checkOutput("handover_m0gnt", {31'd0, m0_gnt}, 32'd1);
    checkOutput("handover_m1din", m1_din, 32'd0);
    checkOutput("handover_m0din", m0_din, 32'h0BAD_F00D);
    checkOutput("handover_saddr", s_addr, 32'h44);
    checkOutput("handover_xfer", xfer_cnt, 32'd5);
    m0_req = 1'b0;
    tick();
    checkOutput("handover_idle", {30'd0, owner}, 32'd0);

    // Reset in the middle of an m1 write
    m1_req = 1'b1; m1_wen = 1'b1; m1_addr = 32'h30;
    tick();
    checkOutput("midrst_pre_swen", {31'd0, s_wen}, 32'd1);
    checkOutput("midrst_pre_xfer", xfer_cnt, 32'd6);
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("midrst_swen", {31'd0, s_wen}, 32'd0);
    checkOutput("midrst_owner", {30'd0, owner}, 32'd0);
    checkOutput("midrst_m1gnt", {31'd0, m1_gnt}, 32'd0);
    checkOutput("midrst_xfer", xfer_cnt, 32'd0);
    checkOutput("midrst_saddr", s_addr, 32'd0);
    RESET = 1'b0;
    tick();
    checkOutput("postrst_m1gnt", {31'd0, m1_gnt}, 32'd1);
    checkOutput("postrst_xfer", xfer_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
